// File: rtl/rnn_pkg.sv
// rnn_pkg: layer indices, commit mask, FSM state type and a one-hot helper
// shared by the RNN denoise layer sequencer and its testbench.
package rnn_pkg;

  localparam int NUM_LAYERS = 6;
  localparam int IDX_W      = 3;

  // Layer order through the datapath; bit i of every layer vector is layer i
  localparam int L_DENSE1 = 0;
  localparam int L_GRU1   = 1;
  localparam int L_DENSE2 = 2;
  localparam int L_GRU2   = 3;
  localparam int L_GRU3   = 4;
  localparam int L_DENSE3 = 5;

  // Layers whose completion latches a GRU state register (gru1, gru2, gru3)
  localparam logic [NUM_LAYERS-1:0] COMMIT_MASK = 6'b011010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } seq_state_t;

  // One-hot start vector for a layer index
  function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [IDX_W-1:0] idx);
    return NUM_LAYERS'(1) << idx;
  endfunction

endpackage

// File: rtl/rnn_layer_sequencer_watchdog.sv
// rnn_watchdog: per-layer stall guard. Counts cycles while enabled and flags
// expiry on the edge at which the count would reach TIMEOUT_CYCLES-1.
module rnn_watchdog #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_next;

  assign count_next = {1'b0, count} + (CNT_W+1)'(1);
  assign expire     = enable && (count_next >= LIMIT);

  // Counter restarts whenever the guarded layer is not being driven
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/rnn_layer_sequencer.sv
// rnn_layer_sequencer: steps one frame through dense1 -> gru1 -> dense2 ->
// gru2 -> gru3 -> dense3, inserting a gap cycle after each layer, pulsing the
// GRU commit strobes, guarding each layer with a watchdog and reporting
// per-frame statistics. All outputs are registered.
module rnn_layer_sequencer #(
  parameter int NUM_LAYERS     = rnn_pkg::NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16,
  parameter int FRAME_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  valid,
  output logic [NUM_LAYERS-1:0] start_layer,
  input  logic [NUM_LAYERS-1:0] valid_layer,
  output logic                  commit_vad,
  output logic                  commit_noise,
  output logic                  commit_denoise,
  output logic                  timeout,
  output logic [FRAME_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]      cycle_cnt
);

  import rnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             gap;
  logic             pending;
  logic [CNT_W-1:0] frame_cycles;
  logic [CNT_W-1:0] frame_cycles_inc;
  logic             wd_enable;
  logic             wd_expire;

  // Watchdog runs only while the current layer's start is high
  assign wd_enable = (state == S_RUN) && !gap;

  assign frame_cycles_inc = (frame_cycles == '1) ? frame_cycles
                                                 : frame_cycles + CNT_W'(1);

  rnn_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wd_enable),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Frame FSM with registered handshake, commit and statistics outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      gap            <= 1'b0;
      pending        <= 1'b0;
      busy           <= 1'b0;
      valid          <= 1'b0;
      start_layer    <= '0;
      commit_vad     <= 1'b0;
      commit_noise   <= 1'b0;
      commit_denoise <= 1'b0;
      timeout        <= 1'b0;
      frame_cnt      <= '0;
      cycle_cnt      <= '0;
      frame_cycles   <= '0;
    end else begin
      valid          <= 1'b0;
      commit_vad     <= 1'b0;
      commit_noise   <= 1'b0;
      commit_denoise <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RUN;
            idx          <= '0;
            gap          <= 1'b0;
            busy         <= 1'b1;
            start_layer  <= layer_onehot('0);
            frame_cycles <= CNT_W'(1);
          end
        end
        S_RUN: begin
          frame_cycles <= frame_cycles_inc;
          if (start) begin
            pending <= 1'b1;
          end
          if (gap) begin
            if (idx == LAST_IDX) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              valid     <= 1'b1;
              frame_cnt <= frame_cnt + FRAME_W'(1);
              cycle_cnt <= frame_cycles_inc;
            end else begin
              idx         <= idx + IDX_W'(1);
              gap         <= 1'b0;
              start_layer <= layer_onehot(idx + IDX_W'(1));
            end
          end else if (valid_layer[idx]) begin
            gap         <= 1'b1;
            start_layer <= '0;
            if (COMMIT_MASK[idx]) begin
              commit_vad     <= (idx == IDX_W'(L_GRU1));
              commit_noise   <= (idx == IDX_W'(L_GRU2));
              commit_denoise <= (idx == IDX_W'(L_GRU3));
            end
          end else if (wd_expire) begin
            state       <= S_ERR;
            busy        <= 1'b0;
            start_layer <= '0;
            timeout     <= 1'b1;
            pending     <= 1'b0;
          end
        end
        S_DONE: begin
          if (pending || start) begin
            state        <= S_RUN;
            idx          <= '0;
            gap          <= 1'b0;
            busy         <= 1'b1;
            start_layer  <= layer_onehot('0);
            frame_cycles <= CNT_W'(1);
            pending      <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ERR: begin
          start_layer <= '0;
          busy        <= 1'b0;
          pending     <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
